reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with a per-register scoreboard and a hardware stack-pointer adjuster, for the multi-cycle processor datapath. It provides two combinational read ports, one synchronous write port, and fixed taps for the stack pointer, the load register and the auxiliary register. Busy bits let issue logic stall on registers that still have a write outstanding. It serves decode/issue, and the writeback stage writes into it.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, index width; DEPTH = 2**ADDR_W registers
- SP_IDX, 1, stack-pointer register index
- SP_RESET, all ones, stack-pointer reset value
- LOAD_IDX, 6, load-value register index
- LOAD_RESET, 9, load-value register reset value
- AUX_IDX, 5, auxiliary tap index

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-high
- srcA  in  ADDR_W  read port A index
- srcB  in  ADDR_W  read port B index
- ReadA  out  DATA_W  contents of srcA
- ReadB  out  DATA_W  contents of srcB
- busyA  out  1  srcA has a write outstanding
- busyB  out  1  srcB has a write outstanding
- RegWrite  in  1  write enable
- writeReg  in  ADDR_W  write index
- writeValue  in  DATA_W  write data
- Reserve  in  1  marks reserveReg busy; asserted by issue logic
- reserveReg  in  ADDR_W  index to reserve
- SPInc  in  1  stack pointer +1
- SPDec  in  1  stack pointer -1
- SPAddress  out  DATA_W  registers[SP_IDX]
- LoadValue  out  DATA_W  registers[LOAD_IDX]
- RegFive  out  DATA_W  registers[AUX_IDX]

## Operation
- Reset (RST high, at any time, including mid-write):
  - All registers clear to 0, except SP_IDX = SP_RESET and LOAD_IDX = LOAD_RESET.
  - All busy bits clear.
  - Outputs: ReadA/ReadB show the reset contents of srcA/srcB; busyA = busyB = 0; SPAddress = SP_RESET; LoadValue = LOAD_RESET; RegFive = 0.
- Write: when RegWrite = 1 at a rising edge, registers[writeReg] <= writeValue and busy[writeReg] clears.
- Reserve: when Reserve = 1 at a rising edge, busy[reserveReg] sets.
  - Reserve and write to the same index in one cycle: reserve wins. Data is written and busy ends set, because a new producer is in flight.
  - Reserving an already-busy register keeps it set; no counting.
- Stack pointer, when no write targets SP_IDX:
  - SPInc alone: SP <= SP + 1, modulo 2**DATA_W, so all ones wraps to 0.
  - SPDec alone: SP <= SP - 1, so 0 wraps to all ones.
  - SPInc and SPDec together: SP is unchanged.
- Stack pointer with RegWrite to SP_IDX: the write takes priority and SPInc/SPDec are ignored that cycle.
- Index range: all indices are in range by construction. No register is hard-wired to zero.
- Reads: ReadA/ReadB and the three taps are combinational from the register array; busyA = busy[srcA] and busyB = busy[srcB].

## Timing
- Write, reserve and SP-adjust latency: 1 cycle. The new value is visible on the read ports and taps immediately after the edge.
- Read latency: 0 cycles, combinational.
- Reset acts immediately and asynchronously. Release is synchronous to CLK: the first update happens on the first rising edge with RST low.
- Busy protocol:
  - Issue asserts Reserve in the cycle it dispatches a producer.
  - Writeback later asserts RegWrite for the same index.
  - Consumers must stall while busyA/busyB is high.
  - The block never stalls and has no back-pressure.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write forwarding.
  - If RegWrite = 1 and writeReg == srcA, then ReadA = writeValue and busyA = 0 (port B likewise).
  - The taps forward the same way when writeReg matches their index. This includes SP_IDX, where forwarding shows the write value, not the inc/dec result.
  - A same-cycle Reserve does not affect combinational busy.
- Undefined: reads and busy reflect registered state only. A consumer sees a write one cycle after RegWrite.

## Test plan
- Reset check: assert RST mid-cycle with RegWrite = 1 to r3. Required: r3 = 0, SPAddress = 0xFFFF, LoadValue = 9, RegFive = 0, all busy bits = 0; the write is lost.
- Write and forwarding: write 0x1234 to r2 with srcA = 2.
  - Without the macro: ReadA is the old value in the write cycle and 0x1234 after the edge.
  - With the macro: ReadA = 0x1234 in the same cycle.
- Scoreboard: Reserve r4, then busyB = 1 with srcB = 4. Two cycles later RegWrite r4 = 0x00AA; busyB then clears and ReadB = 0x00AA. Repeat with Reserve and RegWrite to r4 in the same cycle: busy[r4] stays 1.
- SP wrap-around:
  - From reset, SPInc gives SP = 0x0000; SPDec then gives 0xFFFF.
  - SPInc and SPDec together leave SP unchanged.
- SP priority: with SP = 0x0100, RegWrite r1 = 0x0200 together with SPDec. Required: SP = 0x0200.
- Parametrised build (DATA_W = 32, ADDR_W = 4): write r15 = 0xDEADBEEF and read it back on both ports. SP from reset with SPInc gives 0x00000000.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bus bundle between decode/issue/writeback and the scoreboarded register
// file.
//   master : issue/writeback side. Drives the read indices, the write port,
//            the reserve request and the stack-pointer adjust strobes.
//   slave  : register file side. Drives the read data, the busy flags and
//            the three fixed taps.
// Parameters: DATA_W (register width), ADDR_W (index width).
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   // read ports
   logic [ADDR_W-1:0] src_a;
   logic [ADDR_W-1:0] src_b;
   logic [DATA_W-1:0] read_a;
   logic [DATA_W-1:0] read_b;
   logic              busy_a;
   logic              busy_b;
   // write port (writeback)
   logic              reg_write;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_value;
   // scoreboard reservation (issue)
   logic              reserve;
   logic [ADDR_W-1:0] reserve_reg;
   // stack-pointer adjust
   logic              sp_inc;
   logic              sp_dec;
   // fixed taps
   logic [DATA_W-1:0] sp_address;
   logic [DATA_W-1:0] load_value;
   logic [DATA_W-1:0] reg_five;

   modport master (
      output src_a, src_b, reg_write, write_reg, write_value,
             reserve, reserve_reg, sp_inc, sp_dec,
      input  read_a, read_b, busy_a, busy_b,
             sp_address, load_value, reg_five
   );

   modport slave (
      input  src_a, src_b, reg_write, write_reg, write_value,
             reserve, reserve_reg, sp_inc, sp_dec,
      output read_a, read_b, busy_a, busy_b,
             sp_address, load_value, reg_five
   );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Register file with a per-register busy scoreboard and a stack-pointer
// adjuster. Two combinational read ports, one synchronous write port, and
// fixed taps for the stack pointer, the load register and the aux register.
//
// Ports:
//   clk : rising-edge clock for all state updates
//   rst : asynchronous, active-high reset; release takes effect on the
//         first rising edge with rst low
//   bus : reg_file_sb_if.slave
//           src_a/src_b -> read_a/read_b, busy_a/busy_b (combinational)
//           reg_write/write_reg/write_value : write, clears busy
//           reserve/reserve_reg             : sets busy (wins over write)
//           sp_inc/sp_dec                   : SP +/-1, both = hold,
//                                             ignored when SP is written
//           sp_address/load_value/reg_five  : fixed taps
//
// Optional feature (macro REGFILE_BYPASS_EN): when defined, a same-cycle
// write is forwarded to the read ports and taps whose index matches, and the
// matching busy output reads 0. When undefined, every output reflects
// registered state only.
// ---------------------------------------------------------------------------
module reg_file_sb #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 3,
   parameter int                SP_IDX     = 1,
   parameter logic [DATA_W-1:0] SP_RESET   = '1,
   parameter int                LOAD_IDX   = 6,
   parameter logic [DATA_W-1:0] LOAD_RESET = DATA_W'(9),
   parameter int                AUX_IDX    = 5
) (
   input logic          clk,
   input logic          rst,
   reg_file_sb_if.slave bus
);
   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] SP_SEL   = ADDR_W'(SP_IDX);
   localparam logic [ADDR_W-1:0] LOAD_SEL = ADDR_W'(LOAD_IDX);
   localparam logic [ADDR_W-1:0] AUX_SEL  = ADDR_W'(AUX_IDX);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic              sp_written;
   logic [DATA_W-1:0] sp_next;

   // A write aimed at the stack pointer overrides any inc/dec that cycle.
   assign sp_written = bus.reg_write && (bus.write_reg == SP_SEL);

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sp_next = regs[SP_SEL];
      if (bus.sp_inc && !bus.sp_dec) begin
         sp_next = regs[SP_SEL] + DATA_W'(1);
      end else if (bus.sp_dec && !bus.sp_inc) begin
         sp_next = regs[SP_SEL] - DATA_W'(1);
      end
   end

   // NOTE: this array is reset on purpose: SP and the load register have
   // defined reset contents that software relies on, and busy must start
   // clear. A plain data RAM without such values would be left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         regs[SP_SEL]   <= SP_RESET;
         regs[LOAD_SEL] <= LOAD_RESET;
         busy           <= '0;
      end else begin
         // NOTE: non-blocking assignments; where two assign the same bit in
         // one edge the later one wins, which gives reserve priority over the
         // write's busy-clear.
         if (bus.reg_write) begin
            regs[bus.write_reg] <= bus.write_value;
            busy[bus.write_reg] <= 1'b0;
         end
         if (!sp_written) begin
            regs[SP_SEL] <= sp_next;
         end
         if (bus.reserve) begin
            busy[bus.reserve_reg] <= 1'b1;
         end
      end
   end

   // Forwarding hit per output. Forced low in the registered-only build.
   logic hit_a;
   logic hit_b;
   logic hit_sp;
   logic hit_load;
   logic hit_aux;

`ifdef REGFILE_BYPASS_EN
   assign hit_a    = bus.reg_write && (bus.write_reg == bus.src_a);
   assign hit_b    = bus.reg_write && (bus.write_reg == bus.src_b);
   assign hit_sp   = sp_written;
   assign hit_load = bus.reg_write && (bus.write_reg == LOAD_SEL);
   assign hit_aux  = bus.reg_write && (bus.write_reg == AUX_SEL);
`else
   assign hit_a    = 1'b0;
   assign hit_b    = 1'b0;
   assign hit_sp   = 1'b0;
   assign hit_load = 1'b0;
   assign hit_aux  = 1'b0;
`endif

   assign bus.read_a     = hit_a    ? bus.write_value : regs[bus.src_a];
   assign bus.read_b     = hit_b    ? bus.write_value : regs[bus.src_b];
   // A forwarded write means the producer has completed, so busy reads 0.
   assign bus.busy_a     = hit_a    ? 1'b0 : busy[bus.src_a];
   assign bus.busy_b     = hit_b    ? 1'b0 : busy[bus.src_b];
   assign bus.sp_address = hit_sp   ? bus.write_value : regs[SP_SEL];
   assign bus.load_value = hit_load ? bus.write_value : regs[LOAD_SEL];
   assign bus.reg_five   = hit_aux  ? bus.write_value : regs[AUX_SEL];

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Directed and random stimulus for reg_file_sb against a behavioural model
// (an array of register values and busy flags updated by the block's rules).
// A second instance uses DATA_W = 32, ADDR_W = 4.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
   localparam int SP_IDX   = 1;
   localparam int LOAD_IDX = 6;
   localparam int AUX_IDX  = 5;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) bus ();
   reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

   reg_file_sb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state.
   logic [15:0] m_reg  [8];
   bit          m_busy [8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_reg[i]  = 16'h0000;
         m_busy[i] = 1'b0;
      end
      m_reg[SP_IDX]   = 16'hFFFF;
      m_reg[LOAD_IDX] = 16'd9;
   endtask

   // Expected combinational value of register idx given the inputs now applied.
   function automatic logic [15:0] exp_read(input int idx);
`ifdef REGFILE_BYPASS_EN
      if (bus.reg_write && int'(bus.write_reg) == idx) return bus.write_value;
`endif
      return m_reg[idx];
   endfunction

   function automatic logic exp_busy(input int idx);
`ifdef REGFILE_BYPASS_EN
      if (bus.reg_write && int'(bus.write_reg) == idx) return 1'b0;
`endif
      return m_busy[idx];
   endfunction

   task automatic check_outputs();
      check("read_a",     32'(bus.read_a),     32'(exp_read(int'(bus.src_a))));
      check("read_b",     32'(bus.read_b),     32'(exp_read(int'(bus.src_b))));
      check("busy_a",     32'(bus.busy_a),     32'(exp_busy(int'(bus.src_a))));
      check("busy_b",     32'(bus.busy_b),     32'(exp_busy(int'(bus.src_b))));
      check("sp_address", 32'(bus.sp_address), 32'(exp_read(SP_IDX)));
      check("load_value", 32'(bus.load_value), 32'(exp_read(LOAD_IDX)));
      check("reg_five",   32'(bus.reg_five),   32'(exp_read(AUX_IDX)));
   endtask

   // Apply one rising edge to the model using the inputs currently held.
   task automatic model_update();
      int  w;
      int  sp;
      bit  sp_written;
      w          = int'(bus.write_reg);
      sp_written = bus.reg_write && (w == SP_IDX);
      sp         = int'(m_reg[SP_IDX]) + int'(bus.sp_inc) - int'(bus.sp_dec);
      if (!sp_written) m_reg[SP_IDX] = 16'(sp & 16'hFFFF);
      if (bus.reg_write) begin
         m_reg[w]  = bus.write_value;
         m_busy[w] = 1'b0;
      end
      if (bus.reserve) m_busy[int'(bus.reserve_reg)] = 1'b1;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      bus.src_a       = '0;
      bus.src_b       = '0;
      bus.reg_write   = 1'b0;
      bus.write_reg   = '0;
      bus.write_value = '0;
      bus.reserve     = 1'b0;
      bus.reserve_reg = '0;
      bus.sp_inc      = 1'b0;
      bus.sp_dec      = 1'b0;
   endtask

   task automatic idle2();
      bus2.src_a       = '0;
      bus2.src_b       = '0;
      bus2.reg_write   = 1'b0;
      bus2.write_reg   = '0;
      bus2.write_value = '0;
      bus2.reserve     = 1'b0;
      bus2.reserve_reg = '0;
      bus2.sp_inc      = 1'b0;
      bus2.sp_dec      = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      idle2();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset state.
      check("rst_sp",     32'(bus.sp_address), 32'h0000FFFF);
      check("rst_load",   32'(bus.load_value), 32'd9);
      check("rst_five",   32'(bus.reg_five),   32'd0);
      check("rst_read_a", 32'(bus.read_a),     32'd0);
      check("rst_busy_a", 32'(bus.busy_a),     32'd0);
      check("rst2_sp",    bus2.sp_address,     32'hFFFFFFFF);

      // Write 0x1234 to r2 with src_a = 2.
      bus.src_a       = 3'd2;
      bus.reg_write   = 1'b1;
      bus.write_reg   = 3'd2;
      bus.write_value = 16'h1234;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("wr_same_cycle", 32'(bus.read_a), 32'h1234);
`else
      check("wr_same_cycle", 32'(bus.read_a), 32'h0000);
`endif
      cycle();
      idle();
      bus.src_a = 3'd2;
      #1;
      check("wr_after_edge", 32'(bus.read_a), 32'h1234);

      // Scoreboard: reserve r4, write it two cycles later.
      bus.reserve     = 1'b1;
      bus.reserve_reg = 3'd4;
      bus.src_b       = 3'd4;
      cycle();
      bus.reserve = 1'b0;
      #1;
      check("sb_busy_set", 32'(bus.busy_b), 32'd1);
      cycle();
      cycle();
      check("sb_busy_held", 32'(bus.busy_b), 32'd1);
      bus.reg_write   = 1'b1;
      bus.write_reg   = 3'd4;
      bus.write_value = 16'h00AA;
      cycle();
      bus.reg_write = 1'b0;
      #1;
      check("sb_busy_clr", 32'(bus.busy_b), 32'd0);
      check("sb_read_b",   32'(bus.read_b), 32'h00AA);
      // Reserve and write r4 in the same cycle: reserve wins.
      bus.reserve     = 1'b1;
      bus.reserve_reg = 3'd4;
      bus.reg_write   = 1'b1;
      bus.write_reg   = 3'd4;
      bus.write_value = 16'h00BB;
      cycle();
      idle();
      bus.src_b = 3'd4;
      #1;
      check("sb_both_busy", 32'(bus.busy_b), 32'd1);
      check("sb_both_data", 32'(bus.read_b), 32'h00BB);

      // Stack pointer wrap-around from the reset value.
      bus.sp_inc = 1'b1;
      cycle();
      bus.sp_inc = 1'b0;
      #1;
      check("sp_inc_wrap", 32'(bus.sp_address), 32'h0000);
      bus.sp_dec = 1'b1;
      cycle();
      bus.sp_dec = 1'b0;
      #1;
      check("sp_dec_wrap", 32'(bus.sp_address), 32'hFFFF);
      bus.sp_inc = 1'b1;
      bus.sp_dec = 1'b1;
      cycle();
      idle();
      #1;
      check("sp_both_hold", 32'(bus.sp_address), 32'hFFFF);

      // Write to SP beats SPDec.
      bus.reg_write   = 1'b1;
      bus.write_reg   = 3'(SP_IDX);
      bus.write_value = 16'h0100;
      cycle();
      bus.write_value = 16'h0200;
      bus.sp_dec      = 1'b1;
      cycle();
      idle();
      #1;
      check("sp_write_prio", 32'(bus.sp_address), 32'h0200);

      // Reset in the middle of a write to r3.
      bus.reg_write   = 1'b1;
      bus.write_reg   = 3'd3;
      bus.write_value = 16'h5555;
      cycle();
      bus.write_reg   = 3'd5;
      bus.write_value = 16'h0505;
      bus.reserve     = 1'b1;
      bus.reserve_reg = 3'd6;
      cycle();
      bus.reserve     = 1'b0;
      bus.write_reg   = 3'd3;
      bus.write_value = 16'h7777;
      bus.src_b       = 3'd6;
      @(negedge clk);
      check_outputs();
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      check("mid_rst_sp",   32'(bus.sp_address), 32'hFFFF);
      check("mid_rst_load", 32'(bus.load_value), 32'd9);
      check("mid_rst_five", 32'(bus.reg_five),   32'd0);
      check("mid_rst_busy", 32'(bus.busy_b),     32'd0);
      @(posedge clk);
      #1;
      idle();
      bus.src_a = 3'd3;
      bus.src_b = 3'd6;
      #1;
      check("mid_rst_r3",    32'(bus.read_a), 32'd0);
      check("mid_rst_busy6", 32'(bus.busy_b), 32'd0);
      rst = 1'b0;
      cycle();

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         bus.src_a       = 3'($urandom_range(0, 7));
         bus.src_b       = 3'($urandom_range(0, 7));
         bus.reg_write   = 1'($urandom_range(0, 1));
         bus.write_reg   = 3'($urandom_range(0, 7));
         bus.write_value = 16'($urandom);
         bus.reserve     = ($urandom_range(0, 2) == 0);
         bus.reserve_reg = 3'($urandom_range(0, 7));
         bus.sp_inc      = 1'($urandom_range(0, 1));
         bus.sp_dec      = 1'($urandom_range(0, 1));
         cycle();
      end
      idle();

      // Wide instance: write r15, SP increment from reset.
      bus2.reg_write   = 1'b1;
      bus2.write_reg   = 4'd15;
      bus2.write_value = 32'hDEADBEEF;
      bus2.sp_inc      = 1'b1;
      cycle();
      idle2();
      bus2.src_a = 4'd15;
      bus2.src_b = 4'd15;
      #1;
      check("wide_read_a", bus2.read_a,     32'hDEADBEEF);
      check("wide_read_b", bus2.read_b,     32'hDEADBEEF);
      check("wide_sp_inc", bus2.sp_address, 32'h00000000);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
